// File: rtl/uart_axi_debug_pkg.sv
// Shared types and sizing helpers for the UART-to-AXI4-Lite debug master.
package uart_axi_debug_pkg;

  typedef enum logic [2:0] {
    RX_CMD,
    RX_DATA,
    AR,
    R,
    AW_W,
    B,
    TX
  } state_e;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Header carries the write flag above the address, rounded up to whole bytes.
  function automatic int cmd_bytes(input int addr_w);
    return (addr_w + 8) / 8;
  endfunction

  function automatic int data_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_axi_debug_if.sv
// AXI4-Lite single-beat channel bundle between the debug master and the interconnect.
interface uart_axi_debug_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   ar_addr;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;
  logic [ADDR_W-1:0]   aw_addr;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;

  modport master (
    output ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready, b_resp, b_valid
  );

  modport slave (
    input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    output ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready, b_resp, b_valid
  );
endinterface

// File: rtl/uart_axi_debug_tx_serializer.sv
// Loads a reply word and a byte count, then offers the bytes LSB-first on valid/ready.
module uart_tx_serializer #(
  parameter int WORD_W = 24,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [CNT_W-1:0]  nbytes,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              valid_q, valid_d;

  always_comb begin
    word_d  = word_q;
    left_d  = left_q;
    valid_d = valid_q;
    done    = 1'b0;
    if (load) begin
      word_d  = word;
      left_d  = nbytes;
      valid_d = (nbytes != '0);
    end else if (valid_q && tx_ready) begin
      word_d  = word_q >> 8;
      left_d  = left_q - 1'b1;
      done    = (left_q == CNT_W'(1));
      valid_d = !done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data  = word_q[7:0];
  assign tx_valid = valid_q;

endmodule

// File: rtl/uart_axi_debug.sv
// UART-driven debug master: byte-serial command in, one AXI4-Lite beat out,
// read data / response code returned on the UART TX stream.
//
// state   | meaning
// RX_CMD  | collecting big-endian header bytes (write flag + address)
// RX_DATA | collecting little-endian write payload bytes
// AR      | read address offered, waiting for ar_ready
// R       | r_ready high, waiting for read data
// AW_W    | write address and data offered, each retires on its own handshake
// B       | b_ready high, waiting for write response
// TX      | reply bytes being handed to the UART transmitter
module uart_axi_debug
  import uart_axi_debug_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       uart_rx,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready,
  output logic [7:0]       uart_tx,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  uart_axi_debug_if.master axi
);

  localparam int CMD_BYTES  = cmd_bytes(ADDR_W);
  localparam int DATA_BYTES = data_bytes(DATA_W);
  localparam int HDR_W      = CMD_BYTES * 8;
  localparam int WORD_W     = DATA_W + 8;
  localparam int CNT_MAX    = (CMD_BYTES > DATA_BYTES + 1) ? CMD_BYTES : DATA_BYTES + 1;
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;

  logic              rx_hs;
  logic              ser_load;
  logic [WORD_W-1:0] ser_word;
  logic [CNT_W-1:0]  ser_nbytes;
  logic              ser_done;

  assign rx_hs = uart_rx_valid && rx_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rx_ready_d = rx_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ser_load   = 1'b0;
    ser_word   = '0;
    ser_nbytes = '0;

    case (state_q)
      RX_CMD: if (rx_hs) begin
        hdr_d = (hdr_q << 8) | HDR_W'(uart_rx);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CMD_BYTES - 1)) begin
          cnt_d  = '0;
          addr_d = hdr_d[ADDR_W-1:0];
          if (hdr_d[HDR_W-1]) begin
            state_d = RX_DATA;
          end else begin
            ar_valid_d = 1'b1;
            rx_ready_d = 1'b0;
            state_d    = AR;
          end
        end
      end
      RX_DATA: if (rx_hs) begin
        // Payload arrives LSB byte first: shift in from the top.
        data_d = (data_q >> 8) | (DATA_W'(uart_rx) << (DATA_W - 8));
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
          cnt_d      = '0;
          rx_ready_d = 1'b0;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = AW_W;
        end
      end
      AR: if (axi.ar_ready) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
        state_d    = R;
      end
      R: if (axi.r_valid) begin
        r_ready_d  = 1'b0;
        ser_load   = 1'b1;
        ser_word   = {6'b0, axi.r_resp, axi.r_data};
        ser_nbytes = CNT_W'(DATA_BYTES + 1);
        state_d    = TX;
      end
      AW_W: begin
        if (axi.aw_ready) aw_valid_d = 1'b0;
        if (axi.w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = B;
        end
      end
      B: if (axi.b_valid) begin
        b_ready_d  = 1'b0;
        ser_load   = 1'b1;
        ser_word   = WORD_W'({6'b0, axi.b_resp});
        ser_nbytes = CNT_W'(1);
        state_d    = TX;
      end
      TX: if (ser_done) begin
        rx_ready_d = 1'b1;
        state_d    = RX_CMD;
      end
      default: state_d = RX_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_CMD;
      cnt_q      <= '0;
      hdr_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_ready_q <= 1'b1;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rx_ready_q <= rx_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
    end
  end

  uart_tx_serializer #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) u_tx_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ser_load),
    .word    (ser_word),
    .nbytes  (ser_nbytes),
    .tx_data (uart_tx),
    .tx_valid(uart_tx_valid),
    .tx_ready(uart_tx_ready),
    .done    (ser_done)
  );

  assign uart_rx_ready = rx_ready_q;
  assign axi.ar_addr   = addr_q;
  assign axi.ar_valid  = ar_valid_q;
  assign axi.r_ready   = r_ready_q;
  assign axi.aw_addr   = addr_q;
  assign axi.aw_valid  = aw_valid_q;
  assign axi.w_data    = data_q;
  assign axi.w_strb    = '1;
  assign axi.w_valid   = w_valid_q;
  assign axi.b_ready   = b_ready_q;

endmodule

// File: tb/tb_uart_axi_debug.sv
// Scoreboard bench: default-size bridge plus an 8-bit-address / 32-bit-data bridge.
module tb_uart_axi_debug;
  import uart_axi_debug_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx0, rx1, tx0, tx1;
  logic rx_valid0, rx_valid1, rx_ready0, rx_ready1;
  logic tx_valid0, tx_valid1, tx_ready0, tx_ready1;

  uart_axi_debug_if #(.ADDR_W(18), .DATA_W(16)) axi0 ();
  uart_axi_debug_if #(.ADDR_W(8),  .DATA_W(32)) axi1 ();

  uart_axi_debug #(.ADDR_W(18), .DATA_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx(rx0), .uart_rx_valid(rx_valid0), .uart_rx_ready(rx_ready0),
    .uart_tx(tx0), .uart_tx_valid(tx_valid0), .uart_tx_ready(tx_ready0),
    .axi(axi0)
  );

  uart_axi_debug #(.ADDR_W(8), .DATA_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .uart_rx(rx1), .uart_rx_valid(rx_valid1), .uart_rx_ready(rx_ready1),
    .uart_tx(tx1), .uart_tx_valid(tx_valid1), .uart_tx_ready(tx_ready1),
    .axi(axi1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboards
  logic [63:0] q_ar0[$], q_aw0[$], q_w0[$], q_ar1[$], q_aw1[$], q_w1[$];
  logic [7:0]  q_tx0[$], q_tx1[$];
  logic [15:0] ref_mem [logic [17:0]];
  logic [15:0] slv_mem [logic [17:0]];

  // slave / sink state
  int ar_delay = 3, aw_delay = 3, w_delay = 1, tx_stall = 0;
  int ar_age = 0, aw_age = 0, w_age = 0, stall0 = 0;
  bit rd_pend0, wr_pend0, aw_done0, w_done0, tx_wait0;
  bit rd_pend1, wr_pend1, aw_done1, w_done1;
  logic [17:0] rd_addr0, wr_addr0;
  logic [15:0] wr_data0;
  logic [31:0] mem1, wr_data1;
  logic [1:0]  b_resp_cfg = OKAY;
  logic [7:0]  tx_hold0;

  function automatic int pending(input int d);
    if (d == 0) return q_ar0.size() + q_aw0.size() + q_w0.size() + q_tx0.size();
    return q_ar1.size() + q_aw1.size() + q_w1.size() + q_tx1.size();
  endfunction

  task automatic send_byte(input int d, input logic [7:0] b);
    int n = 0;
    if (d == 0) begin rx0 = b; rx_valid0 = 1'b1; end
    else        begin rx1 = b; rx_valid1 = 1'b1; end
    do begin @(negedge clk); n++; end
    while (!(d == 0 ? rx_ready0 : rx_ready1) && n < 3000);
    if (!(d == 0 ? rx_ready0 : rx_ready1)) check_eq("rx_wait", d == 0 ? rx_ready0 : rx_ready1, 1);
    @(posedge clk); #1;
    if (d == 0) rx_valid0 = 1'b0; else rx_valid1 = 1'b0;
  endtask

  task automatic rd0(input logic [17:0] a);
    logic [23:0] hdr;
    logic [15:0] d;
    logic [1:0]  r;
    hdr = {6'b0, a};
    if (ref_mem.exists(a)) begin d = ref_mem[a]; r = OKAY; end
    else begin d = 16'h0BAD; r = DECERR; end
    q_ar0.push_back(64'(a));
    q_tx0.push_back(d[7:0]); q_tx0.push_back(d[15:8]); q_tx0.push_back({6'b0, r});
    send_byte(0, hdr[23:16]); send_byte(0, hdr[15:8]); send_byte(0, hdr[7:0]);
  endtask

  task automatic wr0(input logic [17:0] a, input logic [15:0] d, input logic [1:0] br);
    logic [23:0] hdr;
    hdr = {1'b1, 5'b0, a};
    ref_mem[a] = d;
    b_resp_cfg = br;
    q_aw0.push_back(64'(a)); q_w0.push_back(64'(d)); q_tx0.push_back({6'b0, br});
    send_byte(0, hdr[23:16]); send_byte(0, hdr[15:8]); send_byte(0, hdr[7:0]);
    send_byte(0, d[7:0]); send_byte(0, d[15:8]);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (pending(d) != 0 && n < 5000) begin @(posedge clk); #1; n++; end
    check_eq(d == 0 ? "drain0" : "drain1", pending(d), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // slave and UART sink drivers: update just after each rising edge
  initial begin
    {axi0.ar_ready, axi0.r_valid, axi0.aw_ready, axi0.w_ready, axi0.b_valid} = '0;
    {axi1.ar_ready, axi1.r_valid, axi1.aw_ready, axi1.w_ready, axi1.b_valid} = '0;
    axi0.r_data = '0; axi0.r_resp = '0; axi0.b_resp = '0;
    axi1.r_data = '0; axi1.r_resp = '0; axi1.b_resp = '0;
    tx_ready0 = 1'b0; tx_ready1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      ar_age = axi0.ar_valid ? ar_age + 1 : 0;
      aw_age = axi0.aw_valid ? aw_age + 1 : 0;
      w_age  = axi0.w_valid  ? w_age + 1  : 0;
      axi0.ar_ready = axi0.ar_valid && (ar_age > ar_delay);
      axi0.aw_ready = axi0.aw_valid && (aw_age > aw_delay);
      axi0.w_ready  = axi0.w_valid  && (w_age > w_delay);
      axi0.r_valid  = rd_pend0;
      axi0.r_data   = slv_mem.exists(rd_addr0) ? slv_mem[rd_addr0] : 16'h0BAD;
      axi0.r_resp   = slv_mem.exists(rd_addr0) ? OKAY : DECERR;
      axi0.b_valid  = wr_pend0;
      axi0.b_resp   = b_resp_cfg;
      tx_ready0 = tx_valid0 && (stall0 >= tx_stall);
      if (tx_valid0 && !tx_ready0) stall0++;
      axi1.ar_ready = axi1.ar_valid;
      axi1.aw_ready = axi1.aw_valid;
      axi1.w_ready  = axi1.w_valid;
      axi1.r_valid  = rd_pend1;
      axi1.r_data   = mem1;
      axi1.r_resp   = OKAY;
      axi1.b_valid  = wr_pend1;
      axi1.b_resp   = EXOKAY;
      tx_ready1 = tx_valid1;
    end
  end

  // monitors: sample on the falling edge, i.e. the handshakes of the next rising edge
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      {rd_pend0, wr_pend0, aw_done0, w_done0, tx_wait0} = '0;
      {rd_pend1, wr_pend1, aw_done1, w_done1} = '0;
      stall0 = 0;
    end else begin
      if (axi0.ar_valid || axi0.r_ready || axi0.aw_valid || axi0.w_valid || axi0.b_ready || tx_valid0)
        check_eq("rx_ready_busy", rx_ready0, 0);
      if (rd_pend0) check_eq("ar_valid_after_hs", axi0.ar_valid, 0);
      if (aw_done0) check_eq("aw_valid_after_hs", axi0.aw_valid, 0);
      if (w_done0)  check_eq("w_valid_after_hs", axi0.w_valid, 0);
      if (tx_wait0) check_eq("tx_hold", {tx_valid0, tx0}, {1'b1, tx_hold0});
      if (axi0.ar_valid && axi0.ar_ready) begin
        if (q_ar0.size() == 0) check_eq("ar_extra", q_ar0.size(), 1);
        else check_eq("ar_addr", axi0.ar_addr, q_ar0.pop_front());
        rd_pend0 = 1'b1; rd_addr0 = axi0.ar_addr;
      end
      if (axi0.r_valid && axi0.r_ready) rd_pend0 = 1'b0;
      if (axi0.aw_valid && axi0.aw_ready) begin
        if (q_aw0.size() == 0) check_eq("aw_extra", q_aw0.size(), 1);
        else check_eq("aw_addr", axi0.aw_addr, q_aw0.pop_front());
        aw_done0 = 1'b1; wr_addr0 = axi0.aw_addr;
      end
      if (axi0.w_valid && axi0.w_ready) begin
        if (q_w0.size() == 0) check_eq("w_extra", q_w0.size(), 1);
        else check_eq("w_data", axi0.w_data, q_w0.pop_front());
        check_eq("w_strb", axi0.w_strb, 2'b11);
        w_done0 = 1'b1; wr_data0 = axi0.w_data;
      end
      if (aw_done0 && w_done0) begin
        slv_mem[wr_addr0] = wr_data0;
        wr_pend0 = 1'b1; aw_done0 = 1'b0; w_done0 = 1'b0;
      end
      if (axi0.b_valid && axi0.b_ready) wr_pend0 = 1'b0;
      if (tx_valid0 && tx_ready0) begin
        if (q_tx0.size() == 0) check_eq("tx_extra", q_tx0.size(), 1);
        else check_eq("tx_byte", tx0, q_tx0.pop_front());
        stall0 = 0;
      end
      tx_wait0 = tx_valid0 && !tx_ready0;
      tx_hold0 = tx0;

      if (axi1.ar_valid && axi1.ar_ready) begin
        if (q_ar1.size() == 0) check_eq("ar32_extra", q_ar1.size(), 1);
        else check_eq("ar32_addr", axi1.ar_addr, q_ar1.pop_front());
        rd_pend1 = 1'b1;
      end
      if (axi1.r_valid && axi1.r_ready) rd_pend1 = 1'b0;
      if (axi1.aw_valid && axi1.aw_ready) begin
        if (q_aw1.size() == 0) check_eq("aw32_extra", q_aw1.size(), 1);
        else check_eq("aw32_addr", axi1.aw_addr, q_aw1.pop_front());
        aw_done1 = 1'b1;
      end
      if (axi1.w_valid && axi1.w_ready) begin
        if (q_w1.size() == 0) check_eq("w32_extra", q_w1.size(), 1);
        else check_eq("w32_data", axi1.w_data, q_w1.pop_front());
        check_eq("w32_strb", axi1.w_strb, 4'hF);
        w_done1 = 1'b1; wr_data1 = axi1.w_data;
      end
      if (aw_done1 && w_done1) begin
        mem1 = wr_data1; wr_pend1 = 1'b1; aw_done1 = 1'b0; w_done1 = 1'b0;
      end
      if (axi1.b_valid && axi1.b_ready) wr_pend1 = 1'b0;
      if (tx_valid1 && tx_ready1) begin
        if (q_tx1.size() == 0) check_eq("tx32_extra", q_tx1.size(), 1);
        else check_eq("tx32_byte", tx1, q_tx1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rx0 = '0; rx1 = '0; rx_valid0 = 1'b0; rx_valid1 = 1'b0;
    mem1 = '0;
    ref_mem[18'h12345] = 16'hBEEF;
    slv_mem[18'h12345] = 16'hBEEF;

    #22;
    check_eq("rst_rx_ready", rx_ready0, 1);
    check_eq("rst_tx_valid", tx_valid0, 0);
    check_eq("rst_tx_data", tx0, 0);
    check_eq("rst_ar_valid", axi0.ar_valid, 0);
    check_eq("rst_r_ready", axi0.r_ready, 0);
    check_eq("rst_aw_valid", axi0.aw_valid, 0);
    check_eq("rst_w_valid", axi0.w_valid, 0);
    check_eq("rst_b_ready", axi0.b_ready, 0);
    check_eq("rst_ar_addr", axi0.ar_addr, 0);
    check_eq("rst_w_data", axi0.w_data, 0);
    check_eq("rst_w_strb", axi0.w_strb, 2'b11);
    check_eq("rst32_rx_ready", rx_ready1, 1);

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // read with delayed ar_ready, then write with W accepted before AW
    rd0(18'h12345);
    drain(0);
    wr0(18'h12345, 16'h1234, SLVERR);
    drain(0);

    // read back under heavy TX back-pressure
    tx_stall = 10;
    rd0(18'h12345);
    drain(0);
    tx_stall = 0;

    // commands queued behind an in-flight transaction
    rd0(18'h00ABC);
    wr0(18'h00ABC, 16'hABCD, OKAY);
    rd0(18'h00ABC);
    drain(0);

    // reset while a read address is stalled
    ar_delay = 100000;
    send_byte(0, 8'h01); send_byte(0, 8'h23); send_byte(0, 8'h45);
    n = 0;
    while (!axi0.ar_valid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("ar_valid_pre_rst", axi0.ar_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid_async_rst", axi0.ar_valid, 0);
    check_eq("rx_ready_async_rst", rx_ready0, 1);
    q_ar0.delete(); q_tx0.delete();
    ar_delay = 2;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rx_ready_after_rst", rx_ready0, 1);
    rd0(18'h12345);
    drain(0);

    // 8-bit address / 32-bit data instance
    q_aw1.push_back(64'h10); q_w1.push_back(64'h12345678); q_tx1.push_back({6'b0, EXOKAY});
    send_byte(1, 8'h80); send_byte(1, 8'h10);
    send_byte(1, 8'h78); send_byte(1, 8'h56); send_byte(1, 8'h34); send_byte(1, 8'h12);
    drain(1);
    q_ar1.push_back(64'h10);
    q_tx1.push_back(8'h78); q_tx1.push_back(8'h56); q_tx1.push_back(8'h34);
    q_tx1.push_back(8'h12); q_tx1.push_back({6'b0, OKAY});
    send_byte(1, 8'h00); send_byte(1, 8'h10);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
